// File: rtl/ft232h_avalon_sys_dma_pingpong_ram.sv
// Two-bank ping-pong DMA buffer: the FT232H side fills one bank while the Avalon DMA
// side drains the other, with commit/release ownership handshaking and sticky error flags.
module ft232h_avalon_sys_dma_pingpong_ram #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BANK_AW    = 10,
  parameter  int RD_LATENCY = 1,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [BANK_AW-1:0]    address,
  input  logic [BE_WIDTH-1:0]   byteenable,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  input  logic [BANK_AW-1:0]    address2,
  input  logic [BE_WIDTH-1:0]   byteenable2,
  input  logic                  chipselect2,
  input  logic                  write2,
  input  logic                  read2,
  input  logic [DATA_WIDTH-1:0] writedata2,
  output logic [DATA_WIDTH-1:0] readdata2,
  output logic                  readdatavalid2,
  input  logic                  wr_commit,
  input  logic [BANK_AW:0]      wr_count,
  output logic                  wr_ready,
  input  logic                  rd_release,
  output logic                  rd_valid,
  output logic [BANK_AW:0]      rd_len,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  err_drop,
  output logic                  err_collide
);

  localparam int LW = BANK_AW + 1;
  localparam int DEPTH = 1 << BANK_AW;
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  logic [1:0]                 r_full;
  logic [1:0][LW-1:0]         r_len;
  logic                       r_wr_bank;
  logic                       r_rd_bank;
  logic                       r_wr_ready;
  logic                       r_rd_valid;
  logic [LW-1:0]              r_rd_len;
  logic                       r_err_drop;
  logic                       r_err_collide;

  logic                       w_commit;
  logic                       w_release;
  logic [LW-1:0]              w_count_sat;
  logic [1:0]                 w_full_nx;
  logic [1:0][LW-1:0]         w_len_nx;
  logic                       w_wr_bank_nx;
  logic                       w_rd_bank_nx;
  logic                       w_wr_ready_nx;
  logic                       w_rd_valid_nx;
  logic [LW-1:0]              w_rd_len_nx;

  logic [DATA_WIDTH-1:0]      r_mem [2*DEPTH];
  logic [BANK_AW:0]           w_addr1;
  logic [BANK_AW:0]           w_addr2;
  logic                       w_we1;
  logic                       w_we2;
  logic                       w_rreq1;
  logic                       w_rreq2;
  logic [DATA_WIDTH-1:0]      r_rd1 [RD_LATENCY];
  logic [DATA_WIDTH-1:0]      r_rd2 [RD_LATENCY];
  logic [RD_LATENCY-1:0]      r_rv1;
  logic [RD_LATENCY-1:0]      r_rv2;

  assign w_commit  = wr_commit & r_wr_ready & (wr_count != {LW{1'b0}});
  assign w_release = rd_release & r_rd_valid;
  assign w_addr1   = {r_wr_bank, address};
  assign w_addr2   = {r_rd_bank, address2};
  assign w_we1     = chipselect & write & r_wr_ready;
  assign w_we2     = chipselect2 & write2;
  assign w_rreq1   = chipselect & read;
  assign w_rreq2   = chipselect2 & read2;

  // Bank state register and registered status/error outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full        <= 2'b00;
      r_len         <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_ready    <= 1'b1;
      r_rd_valid    <= 1'b0;
      r_rd_len      <= {LW{1'b0}};
      r_err_drop    <= 1'b0;
      r_err_collide <= 1'b0;
    end else begin
      r_full        <= w_full_nx;
      r_len         <= w_len_nx;
      r_wr_bank     <= w_wr_bank_nx;
      r_rd_bank     <= w_rd_bank_nx;
      r_wr_ready    <= w_wr_ready_nx;
      r_rd_valid    <= w_rd_valid_nx;
      r_rd_len      <= w_rd_len_nx;
      r_err_drop    <= r_err_drop | (chipselect & write & ~r_wr_ready);
      r_err_collide <= r_err_collide | (w_we1 & w_we2 & (w_addr1 == w_addr2));
    end
  end

  // Next bank state: release is applied first so a freed bank is visible to the commit
  always_comb begin
    w_full_nx    = r_full;
    w_len_nx     = r_len;
    w_rd_bank_nx = r_rd_bank;
    w_wr_bank_nx = r_wr_bank;
    w_count_sat  = (wr_count > LEN_MAX) ? LEN_MAX : wr_count;
    if (w_release) begin
      w_full_nx[r_rd_bank] = 1'b0;
      w_rd_bank_nx         = ~r_rd_bank;
    end else begin
      w_rd_bank_nx = r_rd_bank;
    end
    if (w_commit) begin
      w_full_nx[r_wr_bank] = 1'b1;
      w_len_nx[r_wr_bank]  = w_count_sat;
      w_wr_bank_nx         = w_full_nx[~r_wr_bank] ? r_wr_bank : ~r_wr_bank;
    end else if (!r_wr_ready && w_release) begin
      // producer was stalled on a full bank; hand it the bank just freed
      w_wr_bank_nx = r_rd_bank;
    end else begin
      w_wr_bank_nx = r_wr_bank;
    end
  end

  // Next values of the registered handshake outputs
  always_comb begin
    w_wr_ready_nx = ~w_full_nx[w_wr_bank_nx];
    w_rd_valid_nx = w_full_nx[w_rd_bank_nx];
    if (w_rd_valid_nx) begin
      w_rd_len_nx = w_len_nx[w_rd_bank_nx];
    end else begin
      w_rd_len_nx = {LW{1'b0}};
    end
  end

  // Byte-lane RAM writes (port 1 last so it wins a collision) and read data pipelines
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (w_we2 && byteenable2[b]) r_mem[w_addr2][b*8 +: 8] <= writedata2[b*8 +: 8];
      if (w_we1 && byteenable[b])  r_mem[w_addr1][b*8 +: 8] <= writedata[b*8 +: 8];
    end
    if (w_rreq1) r_rd1[0] <= r_mem[w_addr1];
    if (w_rreq2) r_rd2[0] <= r_mem[w_addr2];
    for (int i = 1; i < RD_LATENCY; i++) begin
      r_rd1[i] <= r_rd1[i-1];
      r_rd2[i] <= r_rd2[i-1];
    end
  end

  // Read-valid pipelines; reset drops every pending return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rv1 <= {RD_LATENCY{1'b0}};
      r_rv2 <= {RD_LATENCY{1'b0}};
    end else begin
      r_rv1[0] <= w_rreq1;
      r_rv2[0] <= w_rreq2;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_rv1[i] <= r_rv1[i-1];
        r_rv2[i] <= r_rv2[i-1];
      end
    end
  end

  assign readdata       = r_rd1[RD_LATENCY-1];
  assign readdata2      = r_rd2[RD_LATENCY-1];
  assign readdatavalid  = r_rv1[RD_LATENCY-1];
  assign readdatavalid2 = r_rv2[RD_LATENCY-1];
  assign wr_ready       = r_wr_ready;
  assign rd_valid       = r_rd_valid;
  assign rd_len         = r_rd_len;
  assign wr_bank        = r_wr_bank;
  assign rd_bank        = r_rd_bank;
  assign err_drop       = r_err_drop;
  assign err_collide    = r_err_collide;

endmodule

// File: tb/tb_ft232h_avalon_sys_dma_pingpong_ram.sv
// Bench for the ping-pong buffer: two instances (read latency 1 and 2) share stimulus;
// read returns are checked against a queue-based scoreboard fed from a word model.
module tb_ft232h_avalon_sys_dma_pingpong_ram;
  localparam int AW = 10;
  localparam int LW = 11;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [AW-1:0] address, address2;
  logic [3:0] byteenable, byteenable2;
  logic chipselect, write, read, chipselect2, write2, read2;
  logic [31:0] writedata, writedata2;
  logic wr_commit, rd_release;
  logic [LW-1:0] wr_count;

  logic [31:0] u1_rd, u1_rd2, u2_rd, u2_rd2;
  logic u1_rdv, u1_rdv2, u2_rdv, u2_rdv2;
  logic u1_wrdy, u1_rv, u1_wb, u1_rb, u1_ed, u1_ec;
  logic u2_wrdy, u2_rv, u2_wb, u2_rb, u2_ed, u2_ec;
  logic [LW-1:0] u1_len, u2_len;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] m [2*DEPTH];
  logic exp_wb = 1'b0;
  logic exp_rb = 1'b0;
  logic exp_wrdy = 1'b1;
  exp_t q11[$], q12[$], q21[$], q22[$];

  ft232h_avalon_sys_dma_pingpong_ram #(.DATA_WIDTH(32), .BANK_AW(AW), .RD_LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .read(read), .writedata(writedata), .readdata(u1_rd), .readdatavalid(u1_rdv),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .write2(write2),
    .read2(read2), .writedata2(writedata2), .readdata2(u1_rd2), .readdatavalid2(u1_rdv2),
    .wr_commit(wr_commit), .wr_count(wr_count), .wr_ready(u1_wrdy), .rd_release(rd_release),
    .rd_valid(u1_rv), .rd_len(u1_len), .wr_bank(u1_wb), .rd_bank(u1_rb),
    .err_drop(u1_ed), .err_collide(u1_ec));

  ft232h_avalon_sys_dma_pingpong_ram #(.DATA_WIDTH(32), .BANK_AW(AW), .RD_LATENCY(2)) u2 (
    .clk(clk), .reset_n(reset_n),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .read(read), .writedata(writedata), .readdata(u2_rd), .readdatavalid(u2_rdv),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .write2(write2),
    .read2(read2), .writedata2(writedata2), .readdata2(u2_rd2), .readdatavalid2(u2_rdv2),
    .wr_commit(wr_commit), .wr_count(wr_count), .wr_ready(u2_wrdy), .rd_release(rd_release),
    .rd_valid(u2_rv), .rd_len(u2_len), .wr_bank(u2_wb), .rd_bank(u2_rb),
    .err_drop(u2_ed), .err_collide(u2_ec));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    chipselect2 = 1'b0; write2 = 1'b0; read2 = 1'b0;
    wr_commit = 1'b0; rd_release = 1'b0;
  endtask

  task automatic mdl_wr(input logic b, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) m[{b, a}][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic p1_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    if (exp_wrdy) mdl_wr(exp_wb, a, d, be);
  endtask

  task automatic p2_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect2 = 1'b1; write2 = 1'b1; address2 = a; writedata2 = d; byteenable2 = be;
    mdl_wr(exp_rb, a, d, be);
  endtask

  task automatic p1_rd(input logic [AW-1:0] a);
    exp_t e;
    chipselect = 1'b1; read = 1'b1; address = a;
    e.d = m[{exp_wb, a}];
    e.due = cyc + 1; q11.push_back(e);
    e.due = cyc + 2; q21.push_back(e);
  endtask

  task automatic p2_rd(input logic [AW-1:0] a);
    exp_t e;
    chipselect2 = 1'b1; read2 = 1'b1; address2 = a;
    e.d = m[{exp_rb, a}];
    e.due = cyc + 1; q12.push_back(e);
    e.due = cyc + 2; q22.push_back(e);
  endtask

  task automatic chk_st(input string tag, input logic wrdy, input logic rv,
                        input logic [LW-1:0] len, input logic wb, input logic rb);
    chk({tag, " u1 wr_ready"}, u1_wrdy, wrdy);
    chk({tag, " u1 rd_valid"}, u1_rv, rv);
    chk({tag, " u1 rd_len"}, u1_len, len);
    chk({tag, " u1 wr_bank"}, u1_wb, wb);
    chk({tag, " u1 rd_bank"}, u1_rb, rb);
    chk({tag, " u2 wr_ready"}, u2_wrdy, wrdy);
    chk({tag, " u2 rd_valid"}, u2_rv, rv);
    chk({tag, " u2 rd_len"}, u2_len, len);
  endtask

  // Scoreboard: every read return must match the oldest outstanding expectation and its cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (u1_rdv) begin
      if (q11.size() == 0) chk("u1 p1 spurious valid", u1_rdv, 1'b0);
      else begin e = q11.pop_front(); chk("u1 p1 data", u1_rd, e.d); chk("u1 p1 cycle", cyc, e.due); end
    end
    if (u1_rdv2) begin
      if (q12.size() == 0) chk("u1 p2 spurious valid", u1_rdv2, 1'b0);
      else begin e = q12.pop_front(); chk("u1 p2 data", u1_rd2, e.d); chk("u1 p2 cycle", cyc, e.due); end
    end
    if (u2_rdv) begin
      if (q21.size() == 0) chk("u2 p1 spurious valid", u2_rdv, 1'b0);
      else begin e = q21.pop_front(); chk("u2 p1 data", u2_rd, e.d); chk("u2 p1 cycle", cyc, e.due); end
    end
    if (u2_rdv2) begin
      if (q22.size() == 0) chk("u2 p2 spurious valid", u2_rdv2, 1'b0);
      else begin e = q22.pop_front(); chk("u2 p2 data", u2_rd2, e.d); chk("u2 p2 cycle", cyc, e.due); end
    end
  end

  task automatic drain(input string tag);
    repeat (4) tick();
    chk({tag, " q11 empty"}, q11.size(), 32'd0);
    chk({tag, " q12 empty"}, q12.size(), 32'd0);
    chk({tag, " q21 empty"}, q21.size(), 32'd0);
    chk({tag, " q22 empty"}, q22.size(), 32'd0);
  endtask

  initial begin
    address = '0; address2 = '0; byteenable = 4'h0; byteenable2 = 4'h0;
    chipselect = 1'b0; write = 1'b0; read = 1'b0; writedata = 32'h0;
    chipselect2 = 1'b0; write2 = 1'b0; read2 = 1'b0; writedata2 = 32'h0;
    wr_commit = 1'b0; rd_release = 1'b0; wr_count = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    chk_st("reset", 1'b1, 1'b0, 11'd0, 1'b0, 1'b0);
    chk("reset err_drop", u1_ed, 1'b0);
    chk("reset err_collide", u1_ec, 1'b0);

    // both banks empty so both ports point at bank 0: same-word collision
    p2_wr(10'd100, 32'h12345678, 4'hF);
    p1_wr(10'd100, 32'hAAAA5555, 4'hF);
    tick();
    chk("collide u1 err_collide", u1_ec, 1'b1);
    chk("collide u2 err_collide", u2_ec, 1'b1);
    chk("collide err_drop", u1_ed, 1'b0);
    p1_wr(10'd101, 32'h00000000, 4'hF); tick();
    p1_wr(10'd101, 32'hFFFFFFFF, 4'h3); tick();
    p1_wr(10'd102, 32'h00000011, 4'hF); tick();
    p2_rd(10'd102); p1_wr(10'd102, 32'h00000022, 4'hF); tick();
    p1_rd(10'd100); p2_rd(10'd101); tick();
    p2_rd(10'd102); tick();
    p2_rd(10'd100); tick();
    chk("model collide word", m[100], 32'hAAAA5555);
    chk("model partial word", m[101], 32'h0000FFFF);
    drain("collide");

    for (int i = 0; i < 16; i++) begin p1_wr(i[AW-1:0], 32'h1000 + i, 4'hF); tick(); end
    wr_commit = 1'b1; wr_count = 11'd16; tick();
    exp_wb = 1'b1;
    chk_st("commit0", 1'b1, 1'b1, 11'd16, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin p2_rd(i[AW-1:0]); tick(); end
    drain("burst");

    p1_wr(10'd0, 32'h2000, 4'hF); tick();
    p1_wr(10'd1, 32'h2001, 4'hF); tick();
    wr_commit = 1'b1; wr_count = 11'd2; tick();
    exp_wrdy = 1'b0;
    chk_st("both full", 1'b0, 1'b1, 11'd16, 1'b1, 1'b0);
    p1_wr(10'd0, 32'hDEADBEEF, 4'hF); tick();
    chk("drop err_drop", u1_ed, 1'b1);
    chk("drop u2 err_drop", u2_ed, 1'b1);

    wr_commit = 1'b1; wr_count = 11'd5; rd_release = 1'b1; tick();
    exp_wb = 1'b0; exp_rb = 1'b1; exp_wrdy = 1'b1;
    chk_st("full commit+release", 1'b1, 1'b1, 11'd2, 1'b0, 1'b1);
    p2_rd(10'd0); tick();
    p2_rd(10'd1); tick();
    chk("model bank1 word0", m[1024], 32'h2000);

    for (int i = 0; i < 4; i++) begin p1_wr(i[AW-1:0], 32'h3000 + i, 4'hF); tick(); end
    wr_commit = 1'b1; wr_count = 11'd4; rd_release = 1'b1; tick();
    exp_wb = 1'b1; exp_rb = 1'b0;
    chk_st("fill commit+release", 1'b1, 1'b1, 11'd4, 1'b1, 1'b0);
    wr_commit = 1'b1; wr_count = 11'd0; tick();
    chk_st("zero commit", 1'b1, 1'b1, 11'd4, 1'b1, 1'b0);
    rd_release = 1'b1; tick();
    exp_rb = 1'b1;
    chk_st("release", 1'b1, 1'b0, 11'd0, 1'b1, 1'b1);
    wr_commit = 1'b1; wr_count = 11'd1029; tick();
    exp_wb = 1'b0;
    chk_st("saturate", 1'b1, 1'b1, 11'd1024, 1'b0, 1'b1);
    drain("mid");

    // reset while reads are still in the latency pipelines
    p2_rd(10'd0); tick();
    p2_rd(10'd1); tick();
    reset_n = 1'b0;
    q11.delete(); q12.delete(); q21.delete(); q22.delete();
    #1;
    chk("rst u1 readdatavalid2", u1_rdv2, 1'b0);
    chk("rst u2 readdatavalid2", u2_rdv2, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_wb = 1'b0; exp_rb = 1'b0; exp_wrdy = 1'b1;
    tick();
    chk_st("post reset", 1'b1, 1'b0, 11'd0, 1'b0, 1'b0);
    chk("post reset err_drop", u1_ed, 1'b0);
    chk("post reset err_collide", u1_ec, 1'b0);
    chk("post reset u2 err_collide", u2_ec, 1'b0);
    wr_commit = 1'b1; wr_count = 11'd4; tick();
    chk_st("post reset commit", 1'b1, 1'b1, 11'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin p2_rd(i[AW-1:0]); tick(); end
    chk("model retained word", m[3], 32'h3003);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
